biriscv_issue_sched: RTL and testbench
======================================

Name: biriscv_issue_sched

Overview:
- In-order dual-issue scheduler between the fetch/decode FIFO output slots and the two execution pipes.
- Each cycle it picks the head instruction for pipe0 and optionally pairs the next one onto pipe1.
- It checks structural limits, intra-pair RAW hazards and a 32-entry register scoreboard for multi-cycle results (load/mul/div).
- It drives the per-slot accept/pop signals back into the FIFO.

Parameters:
SUPPORT_DUAL_ISSUE, 1, 0 forces single issue (pipe1 never valid)
SUPPORT_MULDIV, 1, 0 treats mul/div-flagged instructions as invalid (issued alone, no scoreboard set)

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-high
slot0_valid_i / slot1_valid_i  in  1  FIFO slot valid (slot0 = older, pc[2]=0)
slotN_instr_i  in  32  opcode
slotN_pc_i  in  32  PC
slotN_fault_i  in  1  fetch or page fault
slotN_class_i  in  8  {invalid, exec, lsu, branch, mul, div, csr, rd_valid}
slotN_accept_o  out  1  pop slotN this cycle
stall_i  in  1  execute stage cannot accept; no issue
flush_i  in  1  branch redirect; no issue this cycle
issue0_valid_o / issue1_valid_o  out  1  pipe issue strobes
issueN_instr_o  out  32  issued opcode
issueN_pc_o  out  32  issued PC
issueN_fault_o  out  1  fault passthrough
wb0_valid_i / wb1_valid_i  in  1  writeback of a scoreboarded result
wbN_rd_i  in  5  writeback destination
div_complete_i  in  1  divider finished
div_busy_o  out  1  divider occupied
sb_pending_o  out  32  scoreboard bitmap (bit0 always 0)
dual_issue_count_o  out  32  cycles with both pipes issuing

Behaviour:
- Register fields: rd=instr[11:7], rs1=[19:15], rs2=[24:20]. Hazard checks are conservative: rs1 and rs2 are always checked.
- Head selection: head = slot0 if slot0_valid_i, else slot1. Head always targets pipe0. Pairing is considered only when head = slot0.
- Head issues (issue0_valid_o=1) iff all of the following hold:
  - !stall_i and !flush_i;
  - none of its rs1/rs2/rd(if rd_valid) is pending;
  - not (div and div_busy_q).
  Instructions with a fault or invalid class skip the hazard checks and issue alone.
- Pair (slot1 on pipe1) issues iff all of the following hold:
  - head issues and SUPPORT_DUAL_ISSUE;
  - slot1_valid_i;
  - neither slot is faulted or invalid;
  - slot0 is not branch/csr/div;
  - slot1 is not csr/div;
  - not both lsu; not both mul;
  - slot1 passes the same scoreboard checks;
  - slot1 rs1/rs2/rd does not equal slot0 rd when slot0 rd_valid and rd!=0.
- slotN_accept_o = 1 for exactly the slots issued this cycle. Never pop slot1 without slot0 in the same or an earlier cycle.
- Latency: combinational issue decision; all issueN_* outputs are combinational from the slot inputs.
- Scoreboard pending_q[31:0], set condition: on issue of an lsu with rd_valid, a mul, or a div, set bit rd (rd!=0).
- Scoreboard clear condition: clear bit wbN_rd_i on wbN_valid_i; rd=0 is ignored. Set and clear of the same bit in one cycle -> set wins. Two writebacks to the same rd -> cleared once.
- div_busy_q:
  - set on div issue, cleared on div_complete_i;
  - issue and complete in the same cycle -> stays 1;
  - a second div is blocked while busy.
- flush_i does not clear the scoreboard or div_busy_q; older in-flight ops still write back.
- dual_issue_count_o increments when both issue valids are 1 and wraps at 2^32.
- Reset: pending_q=0, div_busy_q=0, counter=0. With slot valids low, all valid/accept outputs are 0.

Test Plan:
- Two independent ADDs (x1=x2+x3, x4=x5+x6), slots valid, no stall -> issue0/issue1 both 1, both accepts 1, count 0->1.
- slot0 ADD x5=..., slot1 ADD x7=x5+x1 -> only issue0/slot0_accept. Next cycle slot0 invalid -> slot1 issues on pipe0.
- LW x8 issued; next ADD x9=x8+x1 stalls until wb0_valid_i with wb0_rd_i=8; ADD issues the cycle after clear. Same-cycle set x8 plus wb x8 -> bit stays set.
- DIV issued -> div_busy_o=1; second DIV held; div_complete_i -> issues next cycle. Issue and complete together -> busy remains 1.
- Two LW in slots -> single issue (structural). slot0 BEQ + slot1 ADD -> single issue. flush_i or stall_i high -> no valids or accepts.
- Assert rst_i with pending_q=0x100 and div_busy=1 -> next edge all zero. Faulted slot0 issues alone with issue0_fault_o=1 and no scoreboard change.

Source files
------------

// File: rtl/biriscv_issue_sched_if.sv
// Issue-scheduler bus: the two FIFO slots, their pop strobes and the two pipe issue ports.
interface biriscv_issue_sched_if;
  logic        slot0_valid_i;
  logic [31:0] slot0_instr_i;
  logic [31:0] slot0_pc_i;
  logic        slot0_fault_i;
  logic [7:0]  slot0_class_i;
  logic        slot0_accept_o;

  logic        slot1_valid_i;
  logic [31:0] slot1_instr_i;
  logic [31:0] slot1_pc_i;
  logic        slot1_fault_i;
  logic [7:0]  slot1_class_i;
  logic        slot1_accept_o;

  logic        issue0_valid_o;
  logic [31:0] issue0_instr_o;
  logic [31:0] issue0_pc_o;
  logic        issue0_fault_o;

  logic        issue1_valid_o;
  logic [31:0] issue1_instr_o;
  logic [31:0] issue1_pc_o;
  logic        issue1_fault_o;

  modport master (
    output slot0_valid_i, slot0_instr_i, slot0_pc_i, slot0_fault_i, slot0_class_i,
    output slot1_valid_i, slot1_instr_i, slot1_pc_i, slot1_fault_i, slot1_class_i,
    input  slot0_accept_o, slot1_accept_o,
    input  issue0_valid_o, issue0_instr_o, issue0_pc_o, issue0_fault_o,
    input  issue1_valid_o, issue1_instr_o, issue1_pc_o, issue1_fault_o
  );

  modport slave (
    input  slot0_valid_i, slot0_instr_i, slot0_pc_i, slot0_fault_i, slot0_class_i,
    input  slot1_valid_i, slot1_instr_i, slot1_pc_i, slot1_fault_i, slot1_class_i,
    output slot0_accept_o, slot1_accept_o,
    output issue0_valid_o, issue0_instr_o, issue0_pc_o, issue0_fault_o,
    output issue1_valid_o, issue1_instr_o, issue1_pc_o, issue1_fault_o
  );
endinterface

// File: rtl/biriscv_issue_sched.sv
// In-order dual-issue scheduler: head to pipe0, optional pairing of slot1 onto pipe1,
// guarded by a register scoreboard for load/mul/div results and a divider busy flag.
module biriscv_issue_sched #(
  parameter bit SUPPORT_DUAL_ISSUE = 1'b1,
  parameter bit SUPPORT_MULDIV     = 1'b1
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  biriscv_issue_sched_if.slave         bus,
  input  logic                         stall_i,
  input  logic                         flush_i,
  input  logic                         wb0_valid_i,
  input  logic [4:0]                   wb0_rd_i,
  input  logic                         wb1_valid_i,
  input  logic [4:0]                   wb1_rd_i,
  input  logic                         div_complete_i,
  output logic                         div_busy_o,
  output logic [31:0]                  sb_pending_o,
  output logic [31:0]                  dual_issue_count_o
);

  // Class vector bit positions: {invalid, exec, lsu, branch, mul, div, csr, rd_valid}
  localparam int unsigned ClsInvalid = 7;
  localparam int unsigned ClsExec    = 6;
  localparam int unsigned ClsLsu     = 5;
  localparam int unsigned ClsBranch  = 4;
  localparam int unsigned ClsMul     = 3;
  localparam int unsigned ClsDiv     = 2;
  localparam int unsigned ClsCsr     = 1;
  localparam int unsigned ClsRdValid = 0;

  logic [31:0] pending_q, pending_d;
  logic        div_busy_q, div_busy_d;
  logic [31:0] count_q, count_d;

  logic        head_is_slot0, head_valid;
  logic [31:0] h_instr, h_pc;
  logic        h_fault;
  logic [7:0]  h_cls;
  logic [4:0]  h_rd, h_rs1, h_rs2;
  logic        h_alone, h_haz, h_div, h_mul, h_lsu, h_rdv;

  logic [4:0]  s1_rd, s1_rs1, s1_rs2;
  logic        s1_alone, s1_haz, s1_raw;
  logic        issue0, issue1;
  logic [31:0] set_vec, clr_vec;

  logic        unused_exec;
  assign unused_exec = ^{h_cls[ClsExec], bus.slot1_class_i[ClsExec]};

  always_comb begin
    head_is_slot0 = bus.slot0_valid_i;
    head_valid    = bus.slot0_valid_i | bus.slot1_valid_i;
    h_instr       = head_is_slot0 ? bus.slot0_instr_i : bus.slot1_instr_i;
    h_pc          = head_is_slot0 ? bus.slot0_pc_i    : bus.slot1_pc_i;
    h_fault       = head_is_slot0 ? bus.slot0_fault_i : bus.slot1_fault_i;
    h_cls         = head_is_slot0 ? bus.slot0_class_i : bus.slot1_class_i;
    h_rd          = h_instr[11:7];
    h_rs1         = h_instr[19:15];
    h_rs2         = h_instr[24:20];

    // Faulted or invalid ops (including mul/div without the unit) bypass all checks
    h_alone = h_fault | h_cls[ClsInvalid] |
              (!SUPPORT_MULDIV & (h_cls[ClsMul] | h_cls[ClsDiv]));
    h_div   = h_cls[ClsDiv] & !h_alone;
    h_mul   = h_cls[ClsMul] & !h_alone;
    h_lsu   = h_cls[ClsLsu] & !h_alone;
    h_rdv   = h_cls[ClsRdValid];
    h_haz   = pending_q[h_rs1] | pending_q[h_rs2] | (h_rdv & pending_q[h_rd]);

    issue0 = head_valid & !stall_i & !flush_i &
             (h_alone | (!h_haz & !(h_div & div_busy_q)));

    s1_rd    = bus.slot1_instr_i[11:7];
    s1_rs1   = bus.slot1_instr_i[19:15];
    s1_rs2   = bus.slot1_instr_i[24:20];
    s1_alone = bus.slot1_fault_i | bus.slot1_class_i[ClsInvalid] |
               (!SUPPORT_MULDIV & (bus.slot1_class_i[ClsMul] | bus.slot1_class_i[ClsDiv]));
    s1_haz   = pending_q[s1_rs1] | pending_q[s1_rs2] |
               (bus.slot1_class_i[ClsRdValid] & pending_q[s1_rd]);
    s1_raw   = h_rdv & (h_rd != 5'd0) &
               ((s1_rs1 == h_rd) | (s1_rs2 == h_rd) | (s1_rd == h_rd));

    issue1 = SUPPORT_DUAL_ISSUE & issue0 & head_is_slot0 & bus.slot1_valid_i &
             !h_alone & !s1_alone &
             !(h_cls[ClsBranch] | h_cls[ClsCsr] | h_cls[ClsDiv]) &
             !(bus.slot1_class_i[ClsCsr] | bus.slot1_class_i[ClsDiv]) &
             !(h_cls[ClsLsu] & bus.slot1_class_i[ClsLsu]) &
             !(h_cls[ClsMul] & bus.slot1_class_i[ClsMul]) &
             !s1_haz & !s1_raw;
  end

  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (issue0 && ((h_lsu && h_rdv) || h_mul || h_div)) begin
      set_vec[h_rd] = 1'b1;
    end
    if (issue1 && ((bus.slot1_class_i[ClsLsu] && bus.slot1_class_i[ClsRdValid]) ||
                   bus.slot1_class_i[ClsMul])) begin
      set_vec[s1_rd] = 1'b1;
    end
    if (wb0_valid_i) clr_vec[wb0_rd_i] = 1'b1;
    if (wb1_valid_i) clr_vec[wb1_rd_i] = 1'b1;

    // Set wins over a same-cycle writeback; x0 never tracked
    pending_d  = ((pending_q & ~clr_vec) | set_vec) & ~32'd1;
    div_busy_d = (issue0 & h_div) | (div_busy_q & !div_complete_i);
    count_d    = (issue0 & issue1) ? count_q + 32'd1 : count_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pending_q  <= '0;
      div_busy_q <= 1'b0;
      count_q    <= '0;
    end else begin
      pending_q  <= pending_d;
      div_busy_q <= div_busy_d;
      count_q    <= count_d;
    end
  end

  always_comb begin
    bus.issue0_valid_o = issue0;
    bus.issue0_instr_o = h_instr;
    bus.issue0_pc_o    = h_pc;
    bus.issue0_fault_o = h_fault;
    bus.issue1_valid_o = issue1;
    bus.issue1_instr_o = bus.slot1_instr_i;
    bus.issue1_pc_o    = bus.slot1_pc_i;
    bus.issue1_fault_o = bus.slot1_fault_i;
    // Slot1 is popped either as the pair or as the head once slot0 has drained
    bus.slot0_accept_o = head_is_slot0 & issue0;
    bus.slot1_accept_o = head_is_slot0 ? issue1 : issue0;
  end

  assign div_busy_o         = div_busy_q;
  assign sb_pending_o       = pending_q;
  assign dual_issue_count_o = count_q;

endmodule

// File: tb/tb_biriscv_issue_sched.sv
// Directed bench for biriscv_issue_sched; expectations queued per cycle, checked by a monitor.
module tb_biriscv_issue_sched;

  localparam logic [7:0] C_ALU = 8'b0100_0001;
  localparam logic [7:0] C_LD  = 8'b0010_0001;
  localparam logic [7:0] C_BR  = 8'b0001_0000;
  localparam logic [7:0] C_DIV = 8'b0000_0101;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall, flush, wb0_v, wb1_v, divc;
  logic [4:0]  wb0_rd, wb1_rd;
  logic        div_busy;
  logic [31:0] pend, cnt;

  biriscv_issue_sched_if bus ();

  biriscv_issue_sched dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .bus               (bus),
    .stall_i           (stall),
    .flush_i           (flush),
    .wb0_valid_i       (wb0_v),
    .wb0_rd_i          (wb0_rd),
    .wb1_valid_i       (wb1_v),
    .wb1_rd_i          (wb1_rd),
    .div_complete_i    (divc),
    .div_busy_o        (div_busy),
    .sb_pending_o      (pend),
    .dual_issue_count_o(cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v0, v1, a0, a1, f0, busy;
    logic [31:0] pc0, pc1, pend, cnt;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: one queued expectation per cycle, sampled on the falling edge
  initial begin
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("issue0_valid", {31'd0, bus.issue0_valid_o}, {31'd0, e.v0});
        chk("issue1_valid", {31'd0, bus.issue1_valid_o}, {31'd0, e.v1});
        chk("slot0_accept", {31'd0, bus.slot0_accept_o}, {31'd0, e.a0});
        chk("slot1_accept", {31'd0, bus.slot1_accept_o}, {31'd0, e.a1});
        if (e.v0) begin
          chk("issue0_pc", bus.issue0_pc_o, e.pc0);
          chk("issue0_fault", {31'd0, bus.issue0_fault_o}, {31'd0, e.f0});
        end
        if (e.v1) chk("issue1_pc", bus.issue1_pc_o, e.pc1);
        chk("sb_pending", pend, e.pend);
        chk("div_busy", {31'd0, div_busy}, {31'd0, e.busy});
        chk("dual_count", cnt, e.cnt);
      end else if (!rst && (bus.issue0_valid_o || bus.issue1_valid_o)) begin
        chk("unexpected_issue", {30'd0, bus.issue1_valid_o, bus.issue0_valid_o}, 32'd0);
      end
    end
  end

  function automatic logic [31:0] rtype(input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [4:0] rs2);
    return {7'd0, rs2, rs1, 3'd0, rd, 7'h33};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
    bus.slot0_valid_i = 1'b0; bus.slot0_instr_i = '0; bus.slot0_pc_i = '0;
    bus.slot0_fault_i = 1'b0; bus.slot0_class_i = '0;
    bus.slot1_valid_i = 1'b0; bus.slot1_instr_i = '0; bus.slot1_pc_i = '0;
    bus.slot1_fault_i = 1'b0; bus.slot1_class_i = '0;
    stall = 1'b0; flush = 1'b0; wb0_v = 1'b0; wb0_rd = '0; wb1_v = 1'b0; wb1_rd = '0;
    divc = 1'b0;
  endtask

  task automatic s0(input logic [31:0] instr, input logic [31:0] pc, input logic [7:0] cls);
    bus.slot0_valid_i = 1'b1; bus.slot0_instr_i = instr; bus.slot0_pc_i = pc;
    bus.slot0_class_i = cls;
  endtask

  task automatic s1(input logic [31:0] instr, input logic [31:0] pc, input logic [7:0] cls);
    bus.slot1_valid_i = 1'b1; bus.slot1_instr_i = instr; bus.slot1_pc_i = pc;
    bus.slot1_class_i = cls;
  endtask

  task automatic expect_c(input logic v0, input logic v1, input logic a0, input logic a1,
                          input logic [31:0] pc0, input logic [31:0] pc1, input logic f0,
                          input logic [31:0] p, input logic b, input logic [31:0] c);
    exp_t x;
    x.v0 = v0; x.v1 = v1; x.a0 = a0; x.a1 = a1; x.pc0 = pc0; x.pc1 = pc1; x.f0 = f0;
    x.pend = p; x.busy = b; x.cnt = c;
    q.push_back(x);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    cyc();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    cyc(); expect_c(0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0);                     // reset state
    cyc(); s0(rtype(1, 2, 3), 32'h100, C_ALU); s1(rtype(4, 5, 6), 32'h104, C_ALU);
    expect_c(1, 1, 1, 1, 32'h100, 32'h104, 0, 32'h0, 0, 0);
    cyc(); expect_c(0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 1);
    cyc(); s0(rtype(5, 1, 2), 32'h108, C_ALU); s1(rtype(7, 5, 1), 32'h10c, C_ALU);
    expect_c(1, 0, 1, 0, 32'h108, 0, 0, 32'h0, 0, 1);                      // intra-pair RAW
    cyc(); s1(rtype(7, 5, 1), 32'h10c, C_ALU);
    expect_c(1, 0, 0, 1, 32'h10c, 0, 0, 32'h0, 0, 1);                      // slot1 as head
    cyc(); s0(rtype(8, 1, 0), 32'h110, C_LD);
    expect_c(1, 0, 1, 0, 32'h110, 0, 0, 32'h0, 0, 1);
    cyc(); s0(rtype(9, 8, 1), 32'h114, C_ALU);
    expect_c(0, 0, 0, 0, 0, 0, 0, 32'h100, 0, 1);
    cyc(); s0(rtype(9, 8, 1), 32'h114, C_ALU); wb0_v = 1'b1; wb0_rd = 5'd8;
    expect_c(0, 0, 0, 0, 0, 0, 0, 32'h100, 0, 1);
    cyc(); s0(rtype(9, 8, 1), 32'h114, C_ALU);
    expect_c(1, 0, 1, 0, 32'h114, 0, 0, 32'h0, 0, 1);
    cyc(); s0(rtype(8, 1, 0), 32'h118, C_LD); wb0_v = 1'b1; wb0_rd = 5'd8;
    expect_c(1, 0, 1, 0, 32'h118, 0, 0, 32'h0, 0, 1);
    cyc(); wb0_v = 1'b1; wb0_rd = 5'd8; wb1_v = 1'b1; wb1_rd = 5'd8;
    expect_c(0, 0, 0, 0, 0, 0, 0, 32'h100, 0, 1);                          // set beat clear
    cyc(); s0(rtype(10, 2, 3), 32'h120, C_DIV);
    expect_c(1, 0, 1, 0, 32'h120, 0, 0, 32'h0, 0, 1);
    cyc(); s0(rtype(11, 2, 3), 32'h124, C_DIV);
    expect_c(0, 0, 0, 0, 0, 0, 0, 32'h400, 1, 1);
    cyc(); s0(rtype(11, 2, 3), 32'h124, C_DIV); divc = 1'b1; wb0_v = 1'b1; wb0_rd = 5'd10;
    expect_c(0, 0, 0, 0, 0, 0, 0, 32'h400, 1, 1);
    cyc(); s0(rtype(11, 2, 3), 32'h124, C_DIV);
    expect_c(1, 0, 1, 0, 32'h124, 0, 0, 32'h0, 0, 1);
    cyc(); divc = 1'b1; wb1_v = 1'b1; wb1_rd = 5'd11;
    expect_c(0, 0, 0, 0, 0, 0, 0, 32'h800, 1, 1);
    cyc(); s0(rtype(12, 2, 3), 32'h128, C_DIV); divc = 1'b1;
    expect_c(1, 0, 1, 0, 32'h128, 0, 0, 32'h0, 0, 1);
    cyc(); divc = 1'b1; wb0_v = 1'b1; wb0_rd = 5'd12;
    expect_c(0, 0, 0, 0, 0, 0, 0, 32'h1000, 1, 1);                         // busy held
    cyc(); expect_c(0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 1);
    cyc(); s0(rtype(13, 1, 0), 32'h130, C_LD); s1(rtype(14, 2, 0), 32'h134, C_LD);
    expect_c(1, 0, 1, 0, 32'h130, 0, 0, 32'h0, 0, 1);                      // two lsu
    cyc(); s0(rtype(0, 1, 2), 32'h140, C_BR); s1(rtype(15, 1, 2), 32'h144, C_ALU);
    wb0_v = 1'b1; wb0_rd = 5'd13;
    expect_c(1, 0, 1, 0, 32'h140, 0, 0, 32'h2000, 0, 1);                   // branch alone
    cyc(); s0(rtype(1, 2, 3), 32'h148, C_ALU); s1(rtype(4, 5, 6), 32'h14c, C_ALU);
    flush = 1'b1;
    expect_c(0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 1);
    cyc(); s0(rtype(1, 2, 3), 32'h148, C_ALU); s1(rtype(4, 5, 6), 32'h14c, C_ALU);
    stall = 1'b1;
    expect_c(0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 1);
    cyc(); s0(rtype(16, 1, 0), 32'h150, C_LD); bus.slot0_fault_i = 1'b1;
    s1(rtype(18, 1, 2), 32'h154, C_ALU);
    expect_c(1, 0, 1, 0, 32'h150, 0, 1, 32'h0, 0, 1);                      // fault alone
    cyc(); expect_c(0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 1);
    cyc(); s0(rtype(8, 1, 0), 32'h160, C_LD);
    expect_c(1, 0, 1, 0, 32'h160, 0, 0, 32'h0, 0, 1);
    cyc(); s0(rtype(0, 2, 3), 32'h164, C_DIV);
    expect_c(1, 0, 1, 0, 32'h164, 0, 0, 32'h100, 0, 1);
    cyc(); expect_c(0, 0, 0, 0, 0, 0, 0, 32'h100, 1, 1);
    cyc(); rst = 1'b1;
    expect_c(0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0);                            // async reset
    cyc(); rst = 1'b0;
    expect_c(0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0);
    cyc(); s0(rtype(17, 1, 0), 32'h170, C_LD); s1(rtype(18, 1, 2), 32'h174, C_ALU);
    expect_c(1, 1, 1, 1, 32'h170, 32'h174, 0, 32'h0, 0, 0);
    cyc(); expect_c(0, 0, 0, 0, 0, 0, 0, 32'h20000, 0, 1);
    cyc();
    cyc();
    @(negedge clk);
    chk("queue_drained", q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
